// File: rtl/tone_decoder.sv
// -----------------------------------------------------------------------------
// tone_decoder
//
// Receive-side counterpart of the push-button tone generator. Measures the
// half-period of a square-wave input in clk cycles and classifies it as one
// of the five board notes. Once LOCK_CNT consecutive half-periods match the
// same note, the note is reported as a code and as a one-hot LED vector.
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   rst         in   asynchronous active-high reset
//   sig_in      in   asynchronous square-wave input
//   note        out  [2:0] decoded note, 0 = none, 1..5 = NOM1..NOM5
//   note_valid  out  high while a note is locked
//   led         out  [4:0] one-hot copy of note: note 1 -> led[4],
//                    note 5 -> led[0], all zero when no note
//
// Parameters:
//   TOL        accepted deviation from a nominal half-period (inclusive, +/-)
//   LOCK_CNT   consecutive matching half-periods needed to lock
//   TIMEOUT    clk cycles without an edge before the input counts as silent
//   NOM1..NOM5 nominal half-periods in clk cycles (board defaults)
//
// Build option:
//   TONE_DEC_HYST_EN  when defined, the locked note's match window widens to
//                     +/-2*TOL while LOCKED; all other windows stay +/-TOL.
//                     When undefined, a single +/-TOL window applies always.
// -----------------------------------------------------------------------------
module tone_decoder #(
    parameter int          TOL      = 64,
    parameter int          LOCK_CNT = 4,
    parameter int          TIMEOUT  = 32767,
    parameter logic [15:0] NOM1     = 16'd23889,
    parameter logic [15:0] NOM2     = 16'd21283,
    parameter logic [15:0] NOM3     = 16'd18961,
    parameter logic [15:0] NOM4     = 16'd15944,
    parameter logic [15:0] NOM5     = 16'd14205
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_in,
    output logic [2:0] note,
    output logic       note_valid,
    output logic [4:0] led
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);
    localparam logic [16:0] TOL_V     = 17'(TOL);
`ifdef TONE_DEC_HYST_EN
    localparam logic [16:0] TOL2_V    = 17'(2 * TOL);
`endif
    localparam logic [7:0]  LOCK_V    = 8'(LOCK_CNT);

    // Note k (1..5) nominal lives at slice (k-1)*16.
    localparam logic [79:0] NOM_TABLE = {NOM5, NOM4, NOM3, NOM2, NOM1};

    // -------------------------------------------------------------------------
    // Input path: two-flop synchroniser, one extra stage for the edge
    // detector, and a registered edge pulse. A pin transition therefore
    // shows up as edge_q three clocks later, for either polarity.
    // -------------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic sync3_q;
    logic edge_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q ^ sync3_q;
        end
    end

    // -------------------------------------------------------------------------
    // Half-period counter: cleared by an edge pulse, otherwise counts up and
    // parks at TIMEOUT. The measured half-period is cnt_q + 1 at the pulse.
    // -------------------------------------------------------------------------
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        timeout;
    logic [16:0] meas;

    assign timeout = (cnt_q >= TIMEOUT_V);
    assign meas    = {1'b0, cnt_q} + 17'd1;

    always_comb begin
        cnt_d = cnt_q;
        if (edge_q) begin
            cnt_d = 16'd0;
        end else if (cnt_q < TIMEOUT_V) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // -------------------------------------------------------------------------
    // FSM registers (declared here because the match windows depend on them)
    // -------------------------------------------------------------------------
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [2:0] cand_q;
    logic [2:0] cand_d;
    logic [7:0] streak_q;
    logic [7:0] streak_d;
    logic [2:0] note_q;
    logic [2:0] note_d;
    logic       valid_q;
    logic       valid_d;
    logic [4:0] led_q;
    logic [4:0] led_d;

    // -------------------------------------------------------------------------
    // Window comparators, one per note. Nominals are spaced wider than the
    // widest window pair, so at most one hit bit is ever set.
    // -------------------------------------------------------------------------
    logic [4:0] hit;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_win
            logic [16:0] nom;
            logic [16:0] diff;
            logic [16:0] win;

            assign nom  = {1'b0, NOM_TABLE[gi*16 +: 16]};
            assign diff = (meas >= nom) ? (meas - nom) : (nom - meas);
`ifdef TONE_DEC_HYST_EN
            // Only the note currently locked gets the wide window.
            assign win  = ((state_q == S_LOCKED) && (cand_q == 3'(gi + 1)))
                          ? TOL2_V : TOL_V;
`else
            assign win  = TOL_V;
`endif
            assign hit[gi] = (diff <= win);
        end
    endgenerate

    // Encode the hit vector as a note number (0 = no match).
    logic [2:0] match;

    always_comb begin
        match = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (hit[i]) begin
                match = 3'(i + 1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Streak bookkeeping shared by MEASURE and by leaving LOCKED: what the
    // candidate and streak become after this edge's classification.
    // -------------------------------------------------------------------------
    logic [2:0] tally_cand;
    logic [7:0] tally_streak;
    logic       tally_lock;

    always_comb begin
        tally_cand   = 3'd0;
        tally_streak = 8'd0;
        if (match == 3'd0) begin
            tally_cand   = 3'd0;
            tally_streak = 8'd0;
        end else if (match == cand_q) begin
            tally_cand   = cand_q;
            tally_streak = (streak_q == 8'hFF) ? streak_q : streak_q + 8'd1;
        end else begin
            tally_cand   = match;
            tally_streak = 8'd1;
        end
        tally_lock = (tally_cand != 3'd0) && (tally_streak >= LOCK_V);
    end

    // One-hot LED pattern for a note code.
    function automatic logic [4:0] note_to_led(input logic [2:0] n);
        logic [4:0] l;
        case (n)
            3'd1:    l = 5'b10000;
            3'd2:    l = 5'b01000;
            3'd3:    l = 5'b00100;
            3'd4:    l = 5'b00010;
            3'd5:    l = 5'b00001;
            default: l = 5'b00000;
        endcase
        return l;
    endfunction

    // -------------------------------------------------------------------------
    // FSM next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        streak_d = streak_q;
        note_d   = note_q;
        valid_d  = valid_q;

        if (timeout) begin
            // Silence wins over a coincident edge; that edge then serves as
            // the new reference, which is exactly what IDLE would do with it.
            note_d   = 3'd0;
            valid_d  = 1'b0;
            cand_d   = 3'd0;
            streak_d = 8'd0;
            state_d  = edge_q ? S_MEASURE : S_IDLE;
        end else if (edge_q) begin
            case (state_q)
                S_IDLE: begin
                    // Reference edge only: nothing meaningful to measure yet.
                    state_d  = S_MEASURE;
                    cand_d   = 3'd0;
                    streak_d = 8'd0;
                end
                S_MEASURE: begin
                    cand_d   = tally_cand;
                    streak_d = tally_streak;
                    if (tally_lock) begin
                        state_d = S_LOCKED;
                        note_d  = tally_cand;
                        valid_d = 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (!((match != 3'd0) && (match == cand_q))) begin
                        cand_d   = tally_cand;
                        streak_d = tally_streak;
                        if (tally_lock) begin
                            // Only reachable with LOCK_CNT == 1.
                            note_d  = tally_cand;
                            valid_d = 1'b1;
                        end else begin
                            state_d = S_MEASURE;
                            note_d  = 3'd0;
                            valid_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    cand_d   = 3'd0;
                    streak_d = 8'd0;
                    note_d   = 3'd0;
                    valid_d  = 1'b0;
                end
            endcase
        end

        // LED follows note in the same cycle.
        led_d = note_to_led(note_d);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= 16'd0;
            state_q  <= S_IDLE;
            cand_q   <= 3'd0;
            streak_q <= 8'd0;
            note_q   <= 3'd0;
            valid_q  <= 1'b0;
            led_q    <= 5'd0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            cand_q   <= cand_d;
            streak_q <= streak_d;
            note_q   <= note_d;
            valid_q  <= valid_d;
            led_q    <= led_d;
        end
    end

    assign note       = note_q;
    assign note_valid = valid_q;
    assign led        = led_q;

endmodule
